// File: rtl/rom_download_router.sv
// ROM download router: queues ioctl byte writes and replays them onto
// the SDRAM write ports whose address windows contain each byte.
module rom_download_router #(
    parameter int                  PORTS = 2,
    parameter int                  AW    = 25,
    parameter int                  DEPTH = 4,
    parameter logic [7:0]          INDEX = 8'd0,
    parameter logic [PORTS*AW-1:0] BASE  = {25'h10000, 25'h0},
    parameter logic [PORTS*AW-1:0] SIZE  = {25'h1000000, 25'h1000000}
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ioctl_download,
    input  logic [7:0]                ioctl_index,
    input  logic                      ioctl_wr,
    input  logic [AW-1:0]             ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    output logic [PORTS-1:0]          port_req,
    input  logic [PORTS-1:0]          port_ack,
    output logic [PORTS*(AW-1)-1:0]   port_a,
    output logic [PORTS*2-1:0]        port_ds,
    output logic [PORTS*16-1:0]       port_d,
    output logic                      port_we,
    output logic                      busy,
    output logic                      overflow,
    output logic                      rom_loaded,
    output logic                      core_reset
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 8;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state, state_nx;

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [PW:0]      count;
    logic             wr_last, dl_last, dl_done, dl_fall;
    logic             push, pop, accept, empty, full;
    logic [AW-1:0]    head_a;
    logic [7:0]       head_d;
    logic [AW:0]      diff [PORTS];
    logic [PORTS-1:0] hit, pend, pend_nx;

    assign push    = ioctl_wr & ~wr_last & ioctl_download & (ioctl_index == INDEX);
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign accept  = push & (~full | pop);
    assign dl_fall = dl_last & ~ioctl_download;
    assign {head_a, head_d} = mem[rd_ptr];

    assign port_we = ioctl_download;
    assign busy    = ~empty | (state == WAIT);

    // Borrow out of the AW+1-bit subtraction means the address is below the base.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            diff[p] = {1'b0, head_a} - {1'b0, BASE[p*AW +: AW]};
            hit[p]  = ~diff[p][AW] && (diff[p] < {1'b0, SIZE[p*AW +: AW]});
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        pend_nx  = pend & ~(port_ack ~^ port_req);
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (|hit) state_nx = WAIT;
                end
            end
            WAIT: begin
                if (pend_nx == '0) begin
                    state_nx = IDLE;
                    if (!empty) begin
                        pop = 1'b1;
                        if (|hit) state_nx = WAIT;
                    end
                end
            end
        endcase
        if (pop) pend_nx = hit;
    end

    always_ff @(posedge clk_sys) begin
        if (accept) mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pend       <= '0;
            port_req   <= '0;
            port_a     <= '0;
            port_ds    <= '0;
            port_d     <= '0;
            wr_last    <= 1'b0;
            dl_last    <= 1'b0;
            dl_done    <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            rom_loaded <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            wr_last <= ioctl_wr;
            dl_last <= ioctl_download;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
            if (push & ~accept) overflow <= 1'b1;
            if (pop) begin
                for (int p = 0; p < PORTS; p++) begin
                    if (hit[p]) begin
                        port_req[p]                <= ~port_req[p];
                        port_a[p*(AW-1) +: (AW-1)] <= diff[p][AW-1:1];
                        port_ds[p*2 +: 2]          <= {diff[p][0], ~diff[p][0]};
                        port_d[p*16 +: 16]         <= {head_d, head_d};
                    end
                end
            end
            // A fall seen while still busy is remembered until the queue drains.
            if ((dl_fall | dl_done) & ~busy) begin
                rom_loaded <= 1'b1;
                dl_done    <= 1'b0;
            end else if (dl_fall) begin
                dl_done <= 1'b1;
            end
            core_reset <= ~rom_loaded | busy;
        end
    end

endmodule
